pwm_deadtime_gen: RTL and testbench

- Consumes the 7-bit duty word driven by the Avalon PIO register block (`out_port`).
- Produces one complementary PWM pair (high-side/low-side) with programmable dead time, for one channel of the multi-channel driver.
- The duty word is double-buffered and applied only at period boundaries, so software writes never cause glitches.
- Sits between the PIO output and the gate-driver pins.

---
 rtl/pwm_deadtime_gen.sv | 152 +++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gen.sv
// One complementary PWM channel with dead-time insertion between high and low side.
// The duty word is shadowed and only takes effect at a period wrap (or while disabled).
module pwm_deadtime_gen #(
  parameter int unsigned PRESCALE = 50,
  parameter int unsigned PERIOD   = 100,
  parameter int unsigned DEADTIME = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] duty_in,
  output logic       pwm_h,
  output logic       pwm_l,
  output logic       period_tick,
  output logic [6:0] duty_active
);

  localparam int unsigned DW = 7;
  localparam int unsigned CW = DW;
  localparam int unsigned TW = 8;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DUTY_MAX   = DW'(PERIOD);
  localparam logic [TW-1:0] DT_LOAD    = TW'(DEADTIME);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_HIGH,
    ST_LOW,
    ST_DT_H,
    ST_DT_L
  } state_t;

  logic [PW-1:0] presc_cnt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          raw_q;
  logic [DW-1:0] duty_clamped;
  state_t        state_q, state_d;
  logic [TW-1:0] dt_cnt_q, dt_cnt_d;
  logic          pwm_h_d, pwm_l_d;

  assign tick         = enable && (presc_cnt == PRESC_LAST);
  assign period_tick  = tick && (cnt == CNT_LAST);
  assign duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

  // Prescaler and period counter; both held at zero while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else if (!enable) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
      if (tick) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  // Shadow duty register and raw compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_active <= '0;
      raw_q       <= 1'b0;
    end else begin
      if (!enable || period_tick) begin
        duty_active <= duty_clamped;
      end
      raw_q <= enable && (cnt < duty_active);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_OFF;
      dt_cnt_q <= '0;
      pwm_h    <= 1'b0;
      pwm_l    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      pwm_h    <= pwm_h_d;
      pwm_l    <= pwm_l_d;
    end
  end

  // A raw change inside a dead-time window flips to the opposite gap and restarts it,
  // which swallows pulses shorter than the dead time.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    pwm_h_d  = 1'b0;
    pwm_l_d  = 1'b0;
    if (!enable) begin
      state_d  = ST_OFF;
      dt_cnt_d = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = raw_q ? ST_DT_H : ST_DT_L;
          dt_cnt_d = DT_LOAD;
        end
        ST_HIGH: begin
          if (!raw_q) begin
            state_d  = ST_DT_L;
            dt_cnt_d = DT_LOAD;
          end
        end
        ST_LOW: begin
          if (raw_q) begin
            state_d  = ST_DT_H;
            dt_cnt_d = DT_LOAD;
          end
        end
        ST_DT_H: begin
          if (!raw_q) begin
            state_d  = ST_DT_L;
            dt_cnt_d = DT_LOAD;
          end else if (dt_cnt_q <= TW'(1)) begin
            state_d  = ST_HIGH;
            dt_cnt_d = '0;
          end else begin
            dt_cnt_d = dt_cnt_q - TW'(1);
          end
        end
        ST_DT_L: begin
          if (raw_q) begin
            state_d  = ST_DT_H;
            dt_cnt_d = DT_LOAD;
          end else if (dt_cnt_q <= TW'(1)) begin
            state_d  = ST_LOW;
            dt_cnt_d = '0;
          end else begin
            dt_cnt_d = dt_cnt_q - TW'(1);
          end
        end
        default: begin
          state_d  = ST_OFF;
          dt_cnt_d = '0;
        end
      endcase
    end
    pwm_h_d = (state_d == ST_HIGH);
    pwm_l_d = (state_d == ST_LOW);
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: two instances (dead time 1 and 10) share one stimulus and
// are checked every cycle against a window-based behavioural model plus literal pulse widths.
module tb_pwm_deadtime_gen;

  localparam int PRESCALE = 2;
  localparam int PERIOD   = 100;
  localparam int W1       = 2;   // cycles raw must be stable before an output asserts, dead time 1
  localparam int W10      = 11;  // same for dead time 10
  localparam int HN       = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [6:0] duty_in;
  logic       h1, l1, pt1;
  logic [6:0] da1;
  logic       h10, l10, pt10;
  logic [6:0] da10;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_deadtime_gen #(.PRESCALE(PRESCALE), .PERIOD(PERIOD), .DEADTIME(1)) u_dt1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .duty_in(duty_in),
    .pwm_h(h1), .pwm_l(l1), .period_tick(pt1), .duty_active(da1)
  );

  pwm_deadtime_gen #(.PRESCALE(PRESCALE), .PERIOD(PERIOD), .DEADTIME(10)) u_dt10 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .duty_in(duty_in),
    .pwm_h(h10), .pwm_l(l10), .period_tick(pt10), .duty_active(da10)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Model: an output is on only if enable was high and raw held the matching level
  // for the last w cycles; raw itself comes from an enabled-cycle index.
  int m_n    = 0;
  int m_dact = 0;
  bit m_raw  = 1'b0;
  bit en_h  [HN];
  bit raw_h [HN];

  function automatic bit win(input int w, input bit v);
    for (int k = 0; k < w; k++) begin
      if (!en_h[k] || (raw_h[k] != v)) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    int presc;
    int cnt;
    bit ptick;
    if (!reset_n) begin
      m_n    = 0;
      m_dact = 0;
      m_raw  = 1'b0;
      for (int k = 0; k < HN; k++) begin
        en_h[k]  = 1'b0;
        raw_h[k] = 1'b0;
      end
      chk("rst_h1",  int'(h1),  0);
      chk("rst_l1",  int'(l1),  0);
      chk("rst_pt1", int'(pt1), 0);
      chk("rst_da1", int'(da1), 0);
      chk("rst_h10", int'(h10), 0);
      chk("rst_l10", int'(l10), 0);
    end else begin
      presc = m_n % PRESCALE;
      cnt   = (m_n / PRESCALE) % PERIOD;
      ptick = (enable == 1'b1) && (presc == PRESCALE - 1) && (cnt == PERIOD - 1);
      chk("model_pt1",   int'(pt1),  int'(ptick));
      chk("model_pt10",  int'(pt10), int'(ptick));
      chk("model_da1",   int'(da1),  m_dact);
      chk("model_da10",  int'(da10), m_dact);
      chk("model_h1",    int'(h1),   int'(win(W1, 1'b1)));
      chk("model_l1",    int'(l1),   int'(win(W1, 1'b0)));
      chk("model_h10",   int'(h10),  int'(win(W10, 1'b1)));
      chk("model_l10",   int'(l10),  int'(win(W10, 1'b0)));
      chk("overlap1",    int'(h1 & l1),   0);
      chk("overlap10",   int'(h10 & l10), 0);
      for (int k = HN - 1; k > 0; k--) begin
        en_h[k]  = en_h[k-1];
        raw_h[k] = raw_h[k-1];
      end
      en_h[0]  = (enable == 1'b1);
      raw_h[0] = m_raw;
      m_raw    = (enable == 1'b1) && (cnt < m_dact);
      if (!enable || ptick) m_dact = (int'(duty_in) > PERIOD) ? PERIOD : int'(duty_in);
      m_n = (enable == 1'b1) ? (m_n + 1) % (PRESCALE * PERIOD) : 0;
    end
  end

  // Per-period pulse-width accounting, latched on each period_tick.
  int acc_h1 = 0, acc_l1 = 0, acc_g1 = 0, acc_h10 = 0, acc_l10 = 0;
  int w_h1 = 0, w_l1 = 0, w_g1 = 0, w_h10 = 0, w_l10 = 0, w_space = 0;
  int cyc = 0, last_tick = 0;

  always @(negedge clk) begin
    cyc++;
    acc_h1  += int'(h1);
    acc_l1  += int'(l1);
    acc_g1  += int'(!h1 && !l1);
    acc_h10 += int'(h10);
    acc_l10 += int'(l10);
    if (pt1) begin
      w_h1 = acc_h1; w_l1 = acc_l1; w_g1 = acc_g1; w_h10 = acc_h10; w_l10 = acc_l10;
      acc_h1 = 0; acc_l1 = 0; acc_g1 = 0; acc_h10 = 0; acc_l10 = 0;
      w_space   = cyc - last_tick;
      last_tick = cyc;
    end
  end

  task automatic drive(input bit en, input int d);
    @(posedge clk);
    #1;
    enable  = en;
    duty_in = 7'(d);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pt1 && n < 1000);
    if (!pt1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: actual=no period_tick in %0d cycles required=pulse", n);
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    enable  = 1'b0;
    duty_in = 7'd0;
    repeat (3) @(negedge clk);
    chk("init_pwm_h", int'(h1 | h10), 0);
    chk("init_pwm_l", int'(l1 | l10), 0);
    chk("init_duty",  int'(da1), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_pwm_h", int'(h1 | h10), 0);
    chk("idle_pwm_l", int'(l1 | l10), 0);

    // duty 25
    drive(1'b0, 25);
    drive(1'b1, 25);
    repeat (3) wait_tick(n);
    #1;
    chk("d25_h_clk",  w_h1, 49);
    chk("d25_l_clk",  w_l1, 149);
    chk("d25_gaps",   w_g1, 2);
    chk("d25_period", w_space, 200);
    chk("d25_duty",   int'(da1), 25);

    // mid-period write of 75 only lands at the next wrap
    repeat (100) @(negedge clk);
    drive(1'b1, 75);
    wait_tick(n);
    chk("upd_duty_at_tick", int'(da1), 25);
    #1;
    chk("upd_old_h_clk", w_h1, 49);
    @(negedge clk);
    chk("upd_duty_after", int'(da1), 75);
    wait_tick(n);
    #1;
    chk("d75_h_clk", w_h1, 149);
    chk("d75_l_clk", w_l1, 49);

    // duty 0: low side continuous
    drive(1'b1, 0);
    repeat (3) wait_tick(n);
    #1;
    chk("d0_h_clk", w_h1, 0);
    chk("d0_l_clk", w_l1, 200);
    chk("d0_duty",  int'(da1), 0);

    // duty 127 clamps to full period, no gap at the wrap
    drive(1'b1, 127);
    repeat (3) wait_tick(n);
    #1;
    chk("d127_duty",  int'(da1), 100);
    chk("d127_h_clk", w_h1, 200);
    chk("d127_gaps",  w_g1, 0);
    chk("d127_h10",   w_h10, 200);

    // 2-clk raw pulse shorter than 10-clk dead time is swallowed
    drive(1'b1, 1);
    repeat (3) wait_tick(n);
    #1;
    chk("d1_h10_clk", w_h10, 0);
    chk("d1_l10_clk", w_l10, 188);
    chk("d1_h1_clk",  w_h1, 1);
    chk("d1_l1_clk",  w_l1, 197);

    // disable mid-period, then re-enable
    drive(1'b1, 25);
    repeat (2) wait_tick(n);
    repeat (50) @(negedge clk);
    drive(1'b0, 25);
    @(negedge clk);
    @(negedge clk);
    chk("dis_h1",  int'(h1),  0);
    chk("dis_l1",  int'(l1),  0);
    chk("dis_h10", int'(h10), 0);
    chk("dis_l10", int'(l10), 0);
    drive(1'b0, 127);
    @(negedge clk);
    @(negedge clk);
    chk("dis_clamp", int'(da1), 100);
    drive(1'b0, 40);
    drive(1'b1, 40);
    @(negedge clk);
    chk("reen_duty", int'(da1), 40);
    wait_tick(n);
    chk("reen_first_tick", n, 199);

    // async reset in the middle of a HIGH phase
    drive(1'b1, 127);
    repeat (2) wait_tick(n);
    repeat (20) @(negedge clk);
    chk("pre_reset_high", int'(h1), 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_h",    int'(h1 | h10), 0);
    chk("async_rst_l",    int'(l1 | l10), 0);
    chk("async_rst_tick", int'(pt1), 0);
    chk("async_rst_duty", int'(da1 | da10), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_h", int'(h1 | h10), 0);
    chk("post_rst_l", int'(l1 | l10), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
